// File: rtl/slot_allocator_pkg.sv
// Shared types and sizing for the slot allocator and for consumers of alloc_idx/free_idx.
package slot_pkg;
   localparam int SLOT_SIZE  = 3;
   localparam int SLOT_WIDTH = 1 << SLOT_SIZE;

   typedef logic [SLOT_SIZE-1:0]  slot_idx_t;
   typedef logic [SLOT_SIZE:0]    slot_cnt_t;
   typedef logic [SLOT_WIDTH-1:0] slot_map_t;

   function automatic slot_map_t onehot(input slot_idx_t idx);
      return slot_map_t'(1) << idx;
   endfunction
endpackage

// File: rtl/slot_allocator_if.sv
// Allocation/release handshake between the slot allocator (slave) and its user (master).
interface slot_allocator_if;
   import slot_pkg::*;

   logic      alloc_valid;
   logic      alloc_ready;
   slot_idx_t alloc_idx;
   logic      alloc_fire;
   logic      free_en;
   slot_idx_t free_idx;

   modport slave (
      output alloc_valid, alloc_idx, alloc_fire,
      input  alloc_ready, free_en, free_idx
   );

   modport master (
      input  alloc_valid, alloc_idx, alloc_fire,
      output alloc_ready, free_en, free_idx
   );
endinterface

// File: rtl/slot_allocator_lowest_zero_encoder.sv
// Find-first-zero over an occupancy map; found is low only when every bit is set.
module lowest_zero_encoder #(
   parameter int SIZE = 3
) (
   input  logic [(1<<SIZE)-1:0] i_map,
   output logic [SIZE-1:0]      o_idx,
   output logic                 o_found
);
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      // Scan downward so the last hit is the lowest-numbered zero.
      for (int i = (1 << SIZE) - 1; i >= 0; i--) begin
         if (!i_map[i]) begin
            o_idx   = SIZE'(i);
            o_found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/slot_allocator.sv
// Occupancy tracker handing out the lowest free slot and accepting releases by index.
module slot_allocator
   import slot_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   slot_allocator_if.slave  bus,
   output slot_map_t        o_busy,
   output slot_cnt_t        o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_err
);
   slot_map_t r_busy;
   slot_cnt_t r_count;
   logic      r_err;

   slot_idx_t w_low_idx;
   logic      w_found;
   logic      w_full;
   logic      w_empty;
   logic      w_fire;
   logic      w_free_legal;
   logic      w_free_illegal;
   slot_map_t w_set_mask;
   slot_map_t w_clr_mask;
   slot_map_t w_busy_n;

   lowest_zero_encoder #(.SIZE(SLOT_SIZE)) u_lzenc (
      .i_map   (r_busy),
      .o_idx   (w_low_idx),
      .o_found (w_found)
   );

   assign w_full  = (r_count == slot_cnt_t'(SLOT_WIDTH));
   assign w_empty = (r_count == '0);

   // Offer is gated by rst so nothing fires while reset is asserted.
   assign bus.alloc_valid = ~w_full & ~i_rst;
   assign bus.alloc_idx   = w_low_idx;
   assign w_fire          = bus.alloc_valid & bus.alloc_ready;
   assign bus.alloc_fire  = w_fire;

   assign w_free_legal   = bus.free_en & r_busy[bus.free_idx];
   assign w_free_illegal = bus.free_en & ~r_busy[bus.free_idx];

   assign w_set_mask = w_fire       ? onehot(w_low_idx)    : '0;
   assign w_clr_mask = w_free_legal ? onehot(bus.free_idx) : '0;
   assign w_busy_n   = (r_busy | w_set_mask) & ~w_clr_mask;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_busy <= w_busy_n;
         unique case ({w_fire, w_free_legal})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_free_illegal) r_err <= 1'b1;
      end
   end

   assign o_busy  = r_busy;
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_err   = r_err;

   a_count_pop : assert property (@(posedge i_clk) disable iff (i_rst)
      r_count == slot_cnt_t'($countones(r_busy)));
   a_full_empty : assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_full && w_empty));
   a_fire_free : assert property (@(posedge i_clk) disable iff (i_rst)
      w_fire |-> !r_busy[w_low_idx]);
   a_found_full : assert property (@(posedge i_clk) disable iff (i_rst)
      w_found == !w_full);
endmodule

// File: tb/tb_slot_allocator.sv
// Randomized and directed bench for slot_allocator against a bitmap reference model.
module tb_slot_allocator;
   import slot_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   slot_map_t busy;
   slot_cnt_t count;
   logic      full, empty, err;

   slot_allocator_if intf ();

   slot_allocator dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .bus     (intf.slave),
      .o_busy  (busy),
      .o_count (count),
      .o_full  (full),
      .o_empty (empty),
      .o_err   (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Reference model: one bit per slot plus sticky error.
   bit m_busy [SLOT_WIDTH];
   bit m_err;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < SLOT_WIDTH; i++) c += m_busy[i];
      return c;
   endfunction

   function automatic int m_lowest_free();
      for (int i = 0; i < SLOT_WIDTH; i++) if (!m_busy[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] m_map();
      logic [31:0] m = '0;
      for (int i = 0; i < SLOT_WIDTH; i++) m[i] = m_busy[i];
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOT_WIDTH; i++) m_busy[i] = 1'b0;
         m_err = 1'b0;
      end else begin
         bit fire;
         bit legal;
         int lo;
         int fi;
         lo    = m_lowest_free();
         fi    = int'(intf.free_idx);
         fire  = (m_count() != SLOT_WIDTH) && intf.alloc_ready;
         legal = intf.free_en && m_busy[fi];
         if (intf.free_en && !m_busy[fi]) m_err = 1'b1;
         if (fire)  m_busy[lo] = 1'b1;
         if (legal) m_busy[fi] = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         bit exp_valid;
         exp_valid = !rst && (m_count() != SLOT_WIDTH);
         chk("busy",  32'(busy),  m_map());
         chk("count", 32'(count), 32'(m_count()));
         chk("full",  32'(full),  32'(m_count() == SLOT_WIDTH));
         chk("empty", 32'(empty), 32'(m_count() == 0));
         chk("err",   32'(err),   32'(m_err));
         chk("alloc_valid", 32'(intf.alloc_valid), 32'(exp_valid));
         if (exp_valid)
            chk("alloc_idx", 32'(intf.alloc_idx), 32'(m_lowest_free()));
         chk("alloc_fire", 32'(intf.alloc_fire), 32'(exp_valid && intf.alloc_ready));
      end
   end

   // Inputs change 1 time unit after the edge; state is checked right after.
   task automatic step(input bit r, input bit rdy, input bit fen, input int fidx);
      rst              = r;
      intf.alloc_ready = rdy;
      intf.free_en     = fen;
      intf.free_idx    = slot_idx_t'(fidx);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      intf.alloc_ready = 1'b0;
      intf.free_en     = 1'b0;
      intf.free_idx    = '0;
      @(posedge clk); #1;
      step(1, 0, 0, 0);
      cmp_en = 1'b1;

      // Reset release: empty and offering slot 0.
      step(0, 0, 0, 0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_idx",   32'(intf.alloc_idx), 32'd0);
      chk("rst_valid", 32'(intf.alloc_valid), 32'd1);

      // Fill all eight slots in order.
      for (int i = 0; i < SLOT_WIDTH; i++) begin
         chk("fill_idx", 32'(intf.alloc_idx), 32'(i));
         step(0, 1, 0, 0);
      end
      chk("fill_busy",  32'(busy), 32'hFF);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_full",  32'(full), 32'd1);
      chk("fill_valid", 32'(intf.alloc_valid), 32'd0);
      step(0, 1, 0, 0);
      chk("full_noeff", 32'(busy), 32'hFF);

      // Release 5 while full; re-offered next cycle.
      step(0, 0, 1, 5);
      chk("re_valid", 32'(intf.alloc_valid), 32'd1);
      chk("re_idx",   32'(intf.alloc_idx), 32'd5);
      chk("re_count", 32'(count), 32'd7);
      step(0, 1, 0, 0);
      chk("re_full", 32'(full), 32'd1);

      // busy=0F, fire slot 4 while freeing slot 1.
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
      chk("b0f", 32'(busy), 32'h0F);
      step(0, 1, 1, 1);
      chk("both_busy",  32'(busy), 32'h1D);
      chk("both_count", 32'(count), 32'd4);
      chk("both_idx",   32'(intf.alloc_idx), 32'd1);

      // Illegal free of slot 6; err is sticky.
      step(0, 0, 1, 6);
      chk("ill_err",  32'(err), 32'd1);
      chk("ill_busy", 32'(busy), 32'h1D);
      chk("ill_cnt",  32'(count), 32'd4);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("err_hold", 32'(err), 32'd1);

      // Build 3C, then reset with ready and free_en asserted.
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      chk("b3c", 32'(busy), 32'h3C);
      rst = 1'b1; intf.alloc_ready = 1'b1; intf.free_en = 1'b1; intf.free_idx = 3'd2;
      #1;
      chk("rst_fire",  32'(intf.alloc_fire), 32'd0);
      chk("rst_valid0", 32'(intf.alloc_valid), 32'd0);
      @(posedge clk); #1;
      step(0, 0, 0, 0);
      chk("rst2_busy", 32'(busy), 32'h0);
      chk("rst2_cnt",  32'(count), 32'd0);
      chk("rst2_err",  32'(err), 32'd0);
      chk("rst2_idx",  32'(intf.alloc_idx), 32'd0);

      // Random traffic, frees mostly aimed at busy slots.
      for (int c = 0; c < 10000; c++) begin
         int  fidx;
         bit  fen;
         bit  r;
         r    = ($urandom_range(0, 999) == 0);
         fen  = ($urandom_range(0, 2) == 0);
         fidx = $urandom_range(0, SLOT_WIDTH - 1);
         if ($urandom_range(0, 99) < 97) begin
            for (int k = 0; k < SLOT_WIDTH; k++) begin
               int j = (fidx + k) % SLOT_WIDTH;
               if (m_busy[j]) begin fidx = j; break; end
            end
         end
         step(r, 1'($urandom_range(0, 1)), fen, fidx);
      end

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
